// File: rtl/pdes_mc_pkg.sv
// Shared MC port field widths and arbiter types, common to phold, dummy_mc and the arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pdes_mc_pkg;

    localparam int MC_CMD_W             = 3;
    localparam int MC_SCMD_W            = 4;
    localparam int MC_ADR_W             = 48;
    localparam int MC_SIZE_W            = 2;
    localparam int MC_DATA_W            = 64;
    localparam int MC_RTNCTL_W_DEFAULT  = 32;

    // Outstanding counters are sized for the largest allowed cap (255).
    localparam int OST_W                = 8;

    typedef enum logic {
        RQ_EMPTY = 1'b0,
        RQ_FULL  = 1'b1
    } rq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: combinational grant; the pointer advances on the clock after a grant.
// Backpressure: en low suppresses the grant and freezes the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_WID  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_WID-1:0]  gnt_id
);

    logic [ID_WID-1:0] rr_q;
    logic [ID_WID-1:0] rr_d;
    logic [ID_WID-1:0] cand;
    logic              found;

    // Scan from the pointer; ID_WID-bit addition wraps modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = rr_q + ID_WID'(off);
            if (!found && req[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
        gnt  = '0;
        rr_d = rr_q;
        if (en && found) begin
            gnt[gnt_id] = 1'b1;
            rr_d        = gnt_id + ID_WID'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end

endmodule

// File: rtl/mc_port_arbiter.sv
// Multiplexes NUM_REQ cores onto one MC port, tags rtnctl with the core ID, routes responses back.
// Latency: grant to mc_rq_vld 1 cycle; mc_rs_vld to rsp_vld 1 cycle; 1 transfer/cycle each way.
// Backpressure: mc_rq_stall blocks grants while RQ is full; rsp_stall of the target core drives mc_rs_stall.
module mc_port_arbiter
    import pdes_mc_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ID_WID          = 2,
    parameter int MC_RTNCTL_WIDTH = MC_RTNCTL_W_DEFAULT,
    parameter int OST_MAX         = 15
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_REQ-1:0]                          req_vld,
    input  logic [MC_CMD_W*NUM_REQ-1:0]                 req_cmd,
    input  logic [MC_SCMD_W*NUM_REQ-1:0]                req_scmd,
    input  logic [MC_ADR_W*NUM_REQ-1:0]                 req_vadr,
    input  logic [MC_SIZE_W*NUM_REQ-1:0]                req_size,
    input  logic [MC_DATA_W*NUM_REQ-1:0]                req_data,
    input  logic [(MC_RTNCTL_WIDTH-ID_WID)*NUM_REQ-1:0] req_rtnctl,
    output logic [NUM_REQ-1:0]                          req_gnt,
    output logic                                        mc_rq_vld,
    output logic [MC_CMD_W-1:0]                         mc_rq_cmd,
    output logic [MC_SCMD_W-1:0]                        mc_rq_scmd,
    output logic [MC_ADR_W-1:0]                         mc_rq_vadr,
    output logic [MC_SIZE_W-1:0]                        mc_rq_size,
    output logic [MC_RTNCTL_WIDTH-1:0]                  mc_rq_rtnctl,
    output logic [MC_DATA_W-1:0]                        mc_rq_data,
    output logic                                        mc_rq_flush,
    input  logic                                        mc_rq_stall,
    input  logic                                        mc_rs_vld,
    input  logic [MC_CMD_W-1:0]                         mc_rs_cmd,
    input  logic [MC_SCMD_W-1:0]                        mc_rs_scmd,
    input  logic [MC_RTNCTL_WIDTH-1:0]                  mc_rs_rtnctl,
    input  logic [MC_DATA_W-1:0]                        mc_rs_data,
    output logic                                        mc_rs_stall,
    output logic [NUM_REQ-1:0]                          rsp_vld,
    output logic [MC_CMD_W-1:0]                         rsp_cmd,
    output logic [MC_SCMD_W-1:0]                        rsp_scmd,
    output logic [MC_RTNCTL_WIDTH-ID_WID-1:0]           rsp_rtnctl,
    output logic [MC_DATA_W-1:0]                        rsp_data,
    input  logic [NUM_REQ-1:0]                          rsp_stall,
    output logic                                        idle
);

    localparam int TAG_W = MC_RTNCTL_WIDTH - ID_WID;

    logic [NUM_REQ-1:0]         elig;
    logic                       arb_en;
    logic                       gnt_any;
    logic [ID_WID-1:0]          win_id;

    rq_state_t                  rq_state_q, rq_state_d;
    logic [MC_CMD_W-1:0]        rq_cmd_q, rq_cmd_d;
    logic [MC_SCMD_W-1:0]       rq_scmd_q, rq_scmd_d;
    logic [MC_ADR_W-1:0]        rq_vadr_q, rq_vadr_d;
    logic [MC_SIZE_W-1:0]       rq_size_q, rq_size_d;
    logic [MC_RTNCTL_WIDTH-1:0] rq_rtnctl_q, rq_rtnctl_d;
    logic [MC_DATA_W-1:0]       rq_data_q, rq_data_d;

    logic                       rs_full_q, rs_full_d;
    logic [ID_WID-1:0]          rs_id_q, rs_id_d;
    logic [MC_CMD_W-1:0]        rs_cmd_q, rs_cmd_d;
    logic [MC_SCMD_W-1:0]       rs_scmd_q, rs_scmd_d;
    logic [TAG_W-1:0]           rs_rtnctl_q, rs_rtnctl_d;
    logic [MC_DATA_W-1:0]       rs_data_q, rs_data_d;
    logic                       rs_load;
    logic                       rs_deliver;

    logic [OST_W-1:0]           ost_q [NUM_REQ];
    logic [OST_W-1:0]           ost_d [NUM_REQ];
    logic                       ost_all_zero;

    // A core at its outstanding cap drops out of arbitration until a response returns.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_vld[i] && (ost_q[i] != OST_W'(OST_MAX));
        end
    end

    // Grant only into a free slot or one that empties this cycle; held off during reset.
    assign arb_en  = rst_n && ((rq_state_q == RQ_EMPTY) || !mc_rq_stall);
    assign gnt_any = |req_gnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WID  (ID_WID)
    ) u_rr_arbiter (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (elig),
        .en     (arb_en),
        .gnt    (req_gnt),
        .gnt_id (win_id)
    );

    // RQ next state: fill on grant, drain on unstalled transfer, refill back-to-back.
    always_comb begin
        rq_state_d  = rq_state_q;
        rq_cmd_d    = rq_cmd_q;
        rq_scmd_d   = rq_scmd_q;
        rq_vadr_d   = rq_vadr_q;
        rq_size_d   = rq_size_q;
        rq_rtnctl_d = rq_rtnctl_q;
        rq_data_d   = rq_data_q;
        case (rq_state_q)
            RQ_EMPTY: if (gnt_any) rq_state_d = RQ_FULL;
            RQ_FULL:  if (!mc_rq_stall && !gnt_any) rq_state_d = RQ_EMPTY;
            default:  rq_state_d = RQ_EMPTY;
        endcase
        if (gnt_any) begin
            rq_cmd_d    = req_cmd[win_id*MC_CMD_W +: MC_CMD_W];
            rq_scmd_d   = req_scmd[win_id*MC_SCMD_W +: MC_SCMD_W];
            rq_vadr_d   = req_vadr[win_id*MC_ADR_W +: MC_ADR_W];
            rq_size_d   = req_size[win_id*MC_SIZE_W +: MC_SIZE_W];
            rq_rtnctl_d = {win_id, req_rtnctl[win_id*TAG_W +: TAG_W]};
            rq_data_d   = req_data[win_id*MC_DATA_W +: MC_DATA_W];
        end
    end

    // RQ registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_state_q  <= RQ_EMPTY;
            rq_cmd_q    <= '0;
            rq_scmd_q   <= '0;
            rq_vadr_q   <= '0;
            rq_size_q   <= '0;
            rq_rtnctl_q <= '0;
            rq_data_q   <= '0;
        end else begin
            rq_state_q  <= rq_state_d;
            rq_cmd_q    <= rq_cmd_d;
            rq_scmd_q   <= rq_scmd_d;
            rq_vadr_q   <= rq_vadr_d;
            rq_size_q   <= rq_size_d;
            rq_rtnctl_q <= rq_rtnctl_d;
            rq_data_q   <= rq_data_d;
        end
    end

    assign mc_rq_vld    = (rq_state_q == RQ_FULL);
    assign mc_rq_cmd    = rq_cmd_q;
    assign mc_rq_scmd   = rq_scmd_q;
    assign mc_rq_vadr   = rq_vadr_q;
    assign mc_rq_size   = rq_size_q;
    assign mc_rq_rtnctl = rq_rtnctl_q;
    assign mc_rq_data   = rq_data_q;
    assign mc_rq_flush  = 1'b0;

    // RS next state: stall the MC only while the held response is blocked, so drain and reload overlap.
    always_comb begin
        mc_rs_stall = rs_full_q && rsp_stall[rs_id_q];
        rs_deliver  = rs_full_q && !rsp_stall[rs_id_q];
        rs_load     = mc_rs_vld && !mc_rs_stall;
        rs_full_d   = rs_load || (rs_full_q && !rs_deliver);
        rs_id_d     = rs_id_q;
        rs_cmd_d    = rs_cmd_q;
        rs_scmd_d   = rs_scmd_q;
        rs_rtnctl_d = rs_rtnctl_q;
        rs_data_d   = rs_data_q;
        if (rs_load) begin
            rs_id_d     = mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: ID_WID];
            rs_cmd_d    = mc_rs_cmd;
            rs_scmd_d   = mc_rs_scmd;
            rs_rtnctl_d = mc_rs_rtnctl[TAG_W-1:0];
            rs_data_d   = mc_rs_data;
        end
    end

    // RS registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_full_q   <= 1'b0;
            rs_id_q     <= '0;
            rs_cmd_q    <= '0;
            rs_scmd_q   <= '0;
            rs_rtnctl_q <= '0;
            rs_data_q   <= '0;
        end else begin
            rs_full_q   <= rs_full_d;
            rs_id_q     <= rs_id_d;
            rs_cmd_q    <= rs_cmd_d;
            rs_scmd_q   <= rs_scmd_d;
            rs_rtnctl_q <= rs_rtnctl_d;
            rs_data_q   <= rs_data_d;
        end
    end

    // Steer the held response to its owner only.
    always_comb begin
        rsp_vld = '0;
        if (rs_full_q) rsp_vld[rs_id_q] = 1'b1;
    end

    assign rsp_cmd    = rs_cmd_q;
    assign rsp_scmd   = rs_scmd_q;
    assign rsp_rtnctl = rs_rtnctl_q;
    assign rsp_data   = rs_data_q;

    // Outstanding counts: grant adds, delivery subtracts, both cancel; a stray response cannot underflow.
    always_comb begin
        ost_all_zero = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            ost_d[i] = ost_q[i];
            if (req_gnt[i] && !(rsp_vld[i] && !rsp_stall[i])) begin
                ost_d[i] = ost_q[i] + OST_W'(1);
            end else if (!req_gnt[i] && rsp_vld[i] && !rsp_stall[i] && (ost_q[i] != '0)) begin
                ost_d[i] = ost_q[i] - OST_W'(1);
            end
            if (ost_q[i] != '0) ost_all_zero = 1'b0;
        end
    end

    // Outstanding counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) ost_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) ost_q[i] <= ost_d[i];
        end
    end

    assign idle = (rq_state_q == RQ_EMPTY) && !rs_full_q && ost_all_zero;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter with queue-based scoreboard on both MC request and core response sides.
// Latency: expectations pushed at grant/response issue, popped by a negedge monitor on each transfer.
// Backpressure: monitor only consumes when the corresponding stall is low.
module tb_mc_port_arbiter;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req_vld;
    logic [11:0]    req_cmd;
    logic [15:0]    req_scmd;
    logic [191:0]   req_vadr;
    logic [7:0]     req_size;
    logic [255:0]   req_data;
    logic [119:0]   req_rtnctl;
    logic [3:0]     req_gnt;
    logic           mc_rq_vld;
    logic [2:0]     mc_rq_cmd;
    logic [3:0]     mc_rq_scmd;
    logic [47:0]    mc_rq_vadr;
    logic [1:0]     mc_rq_size;
    logic [31:0]    mc_rq_rtnctl;
    logic [63:0]    mc_rq_data;
    logic           mc_rq_flush;
    logic           mc_rq_stall;
    logic           mc_rs_vld;
    logic [2:0]     mc_rs_cmd;
    logic [3:0]     mc_rs_scmd;
    logic [31:0]    mc_rs_rtnctl;
    logic [63:0]    mc_rs_data;
    logic           mc_rs_stall;
    logic [3:0]     rsp_vld;
    logic [2:0]     rsp_cmd;
    logic [3:0]     rsp_scmd;
    logic [29:0]    rsp_rtnctl;
    logic [63:0]    rsp_data;
    logic [3:0]     rsp_stall;
    logic           idle;

    logic [29:0]    tag [4];

    typedef struct packed {
        logic [31:0] rtnctl;
        logic [47:0] vadr;
        logic [2:0]  cmd;
        logic [63:0] data;
    } rq_exp_t;

    typedef struct packed {
        logic [3:0]  vld;
        logic [29:0] rtnctl;
        logic [63:0] data;
    } rs_exp_t;

    rq_exp_t exp_rq [$];
    rs_exp_t exp_rs [$];
    rq_exp_t mon_rq;
    rs_exp_t mon_rs;

    int n_checks;
    int n_errors;
    int cnt [4];

    mc_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_cmd      (req_cmd),
        .req_scmd     (req_scmd),
        .req_vadr     (req_vadr),
        .req_size     (req_size),
        .req_data     (req_data),
        .req_rtnctl   (req_rtnctl),
        .req_gnt      (req_gnt),
        .mc_rq_vld    (mc_rq_vld),
        .mc_rq_cmd    (mc_rq_cmd),
        .mc_rq_scmd   (mc_rq_scmd),
        .mc_rq_vadr   (mc_rq_vadr),
        .mc_rq_size   (mc_rq_size),
        .mc_rq_rtnctl (mc_rq_rtnctl),
        .mc_rq_data   (mc_rq_data),
        .mc_rq_flush  (mc_rq_flush),
        .mc_rq_stall  (mc_rq_stall),
        .mc_rs_vld    (mc_rs_vld),
        .mc_rs_cmd    (mc_rs_cmd),
        .mc_rs_scmd   (mc_rs_scmd),
        .mc_rs_rtnctl (mc_rs_rtnctl),
        .mc_rs_data   (mc_rs_data),
        .mc_rs_stall  (mc_rs_stall),
        .rsp_vld      (rsp_vld),
        .rsp_cmd      (rsp_cmd),
        .rsp_scmd     (rsp_scmd),
        .rsp_rtnctl   (rsp_rtnctl),
        .rsp_data     (rsp_data),
        .rsp_stall    (rsp_stall),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0]  cmd_of(int i);  return 3'(i + 1);                 endfunction
    function automatic logic [47:0] vadr_of(int i); return 48'h1000 + 48'(i * 64);    endfunction
    function automatic logic [63:0] data_of(int i); return 64'hDA7A_0000 + 64'(i);    endfunction

    // Per-core request fields are fixed functions of the core index plus a per-test tag.
    always_comb begin
        req_cmd = '0; req_scmd = '0; req_vadr = '0; req_size = '0; req_data = '0; req_rtnctl = '0;
        for (int i = 0; i < 4; i++) begin
            req_cmd[i*3 +: 3]     = cmd_of(i);
            req_scmd[i*4 +: 4]    = 4'(i);
            req_vadr[i*48 +: 48]  = vadr_of(i);
            req_size[i*2 +: 2]    = 2'd3;
            req_data[i*64 +: 64]  = data_of(i);
            req_rtnctl[i*30 +: 30] = tag[i];
        end
    end

    function automatic rq_exp_t exp_of(int i);
        rq_exp_t e;
        e.rtnctl = {2'(i), tag[i]};
        e.vadr   = vadr_of(i);
        e.cmd    = cmd_of(i);
        e.data   = data_of(i);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rs(input int id, input logic [29:0] t, input logic [63:0] d);
        rs_exp_t e;
        mc_rs_vld    = 1'b1;
        mc_rs_cmd    = 3'd2;
        mc_rs_scmd   = 4'd0;
        mc_rs_rtnctl = {2'(id), t};
        mc_rs_data   = d;
        e.vld    = 4'(1 << id);
        e.rtnctl = t;
        e.data   = d;
        exp_rs.push_back(e);
    endtask

    task automatic do_reset();
        chk("drain_rq", 64'(exp_rq.size()), 64'd0);
        chk("drain_rs", 64'(exp_rs.size()), 64'd0);
        rst_n = 1'b0; req_vld = '0; mc_rq_stall = 1'b0; mc_rs_vld = 1'b0; rsp_stall = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: consume one expectation per completed transfer on either side.
    always @(negedge clk) begin
        if (rst_n && mc_rq_vld && !mc_rq_stall) begin
            if (exp_rq.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL rq_unexpected: got rtnctl %0h expected no request", mc_rq_rtnctl);
            end else begin
                mon_rq = exp_rq.pop_front();
                chk("rq_rtnctl", 64'(mc_rq_rtnctl), 64'(mon_rq.rtnctl));
                chk("rq_vadr",   64'(mc_rq_vadr),   64'(mon_rq.vadr));
                chk("rq_cmd",    64'(mc_rq_cmd),    64'(mon_rq.cmd));
                chk("rq_data",   mc_rq_data,        mon_rq.data);
            end
        end
        if (rst_n && |(rsp_vld & ~rsp_stall)) begin
            if (exp_rs.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL rs_unexpected: got rsp_vld %0h expected no response", rsp_vld);
            end else begin
                mon_rs = exp_rs.pop_front();
                chk("rs_vld",    64'(rsp_vld),    64'(mon_rs.vld));
                chk("rs_rtnctl", 64'(rsp_rtnctl), 64'(mon_rs.rtnctl));
                chk("rs_data",   rsp_data,        mon_rs.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; req_vld = '0; mc_rq_stall = 1'b0; rsp_stall = '0;
        mc_rs_vld = 1'b0; mc_rs_cmd = '0; mc_rs_scmd = '0; mc_rs_rtnctl = '0; mc_rs_data = '0;
        for (int i = 0; i < 4; i++) begin tag[i] = '0; cnt[i] = 0; end

        // Reset values.
        #3;
        chk("rst_mc_rq_vld", 64'(mc_rq_vld), 64'd0);
        chk("rst_mc_rq_rtnctl", 64'(mc_rq_rtnctl), 64'd0);
        chk("rst_req_gnt", 64'(req_gnt), 64'd0);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_mc_rs_stall", 64'(mc_rs_stall), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_flush", 64'(mc_rq_flush), 64'd0);
        tick();
        rst_n = 1'b1;

        // Single request from core 2 and its echoed response.
        tag[2] = 30'h5; req_vld = 4'b0100;
        @(negedge clk);
        chk("t1_gnt", 64'(req_gnt), 64'h4);
        exp_rq.push_back(exp_of(2));
        tick(); req_vld = '0;
        @(negedge clk);
        chk("t1_rq_vld", 64'(mc_rq_vld), 64'd1);
        chk("t1_rq_rtnctl", 64'(mc_rq_rtnctl), 64'h8000_0005);
        chk("t1_busy", 64'(idle), 64'd0);
        tick(); send_rs(2, 30'h5, 64'hCAFE);
        tick(); mc_rs_vld = 1'b0;
        @(negedge clk);
        chk("t1_rsp_vld", 64'(rsp_vld), 64'h4);
        chk("t1_rsp_rtnctl", 64'(rsp_rtnctl), 64'h5);
        tick();
        @(negedge clk);
        chk("t1_idle", 64'(idle), 64'd1);
        tick();

        // Fairness: four continuous requesters, one grant per cycle in rotation.
        do_reset();
        for (int i = 0; i < 4; i++) tag[i] = 30'h100 + 30'(i);
        req_vld = 4'hF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("t2_gnt", 64'(req_gnt), 64'(1 << (c % 4)));
            exp_rq.push_back(exp_of(c % 4));
            for (int i = 0; i < 4; i++) if (req_gnt[i]) cnt[i]++;
            tick();
        end
        req_vld = '0;
        for (int i = 0; i < 4; i++) chk("t2_cnt", 64'(cnt[i]), 64'd4);
        tick(); tick();

        // Request backpressure: RQ held under stall, transfer and regrant on release.
        do_reset();
        tag[0] = 30'h300; tag[1] = 30'h301; req_vld = 4'b0001;
        @(negedge clk);
        chk("t3_gnt0", 64'(req_gnt), 64'h1);
        exp_rq.push_back(exp_of(0));
        tick(); req_vld = 4'b0010; mc_rq_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_gnt_stall", 64'(req_gnt), 64'd0);
            chk("t3_hold_rtnctl", 64'(mc_rq_rtnctl), 64'({2'd0, 30'h300}));
            chk("t3_hold_vld", 64'(mc_rq_vld), 64'd1);
            tick();
        end
        mc_rq_stall = 1'b0;
        @(negedge clk);
        chk("t3_gnt_release", 64'(req_gnt), 64'h2);
        exp_rq.push_back(exp_of(1));
        tick(); req_vld = '0;
        tick(); tick();

        // Outstanding cap on core 0, then one response re-enables it.
        do_reset();
        tag[0] = 30'h400; tag[1] = 30'h401; req_vld = 4'b0001;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk("t4_gnt0", 64'(req_gnt), 64'h1);
            exp_rq.push_back(exp_of(0));
            tick();
        end
        req_vld = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_capped", 64'(req_gnt), 64'h2);
            exp_rq.push_back(exp_of(1));
            tick();
        end
        send_rs(0, 30'h400, 64'h44);
        @(negedge clk);
        chk("t4_capped_rs", 64'(req_gnt), 64'h2);
        exp_rq.push_back(exp_of(1));
        tick(); mc_rs_vld = 1'b0;
        @(negedge clk);
        chk("t4_capped_dlv", 64'(req_gnt), 64'h2);
        exp_rq.push_back(exp_of(1));
        tick();
        @(negedge clk);
        chk("t4_reenable", 64'(req_gnt), 64'h1);
        exp_rq.push_back(exp_of(0));
        tick(); req_vld = '0;
        tick(); tick();

        // Response backpressure on core 1, then simultaneous grant and delivery.
        do_reset();
        tag[1] = 30'h501; req_vld = 4'b0010;
        @(negedge clk);
        chk("t5_gnt", 64'(req_gnt), 64'h2);
        exp_rq.push_back(exp_of(1));
        tick(); req_vld = '0;
        send_rs(1, 30'h55, 64'h5555); rsp_stall = 4'b0010;
        tick(); send_rs(1, 30'h66, 64'h6666);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_mc_rs_stall", 64'(mc_rs_stall), 64'd1);
            chk("t5_rsp_vld", 64'(rsp_vld), 64'h2);
            chk("t5_rsp_hold", 64'(rsp_rtnctl), 64'h55);
            tick();
        end
        rsp_stall = '0; req_vld = 4'b0010;
        @(negedge clk);
        chk("t5_gnt_dlv", 64'(req_gnt), 64'h2);
        exp_rq.push_back(exp_of(1));
        tick(); req_vld = '0; mc_rs_vld = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_idle", 64'(idle), 64'd1);
        tick();

        // Asynchronous reset in the middle of a burst with a response held.
        do_reset();
        for (int i = 0; i < 4; i++) tag[i] = 30'h600 + 30'(i);
        req_vld = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t6_gnt", 64'(req_gnt), 64'(1 << c));
            exp_rq.push_back(exp_of(c));
            tick();
        end
        mc_rs_vld = 1'b1; mc_rs_cmd = 3'd2; mc_rs_rtnctl = {2'd0, 30'h600}; mc_rs_data = 64'h66;
        @(negedge clk);
        chk("t6_gnt", 64'(req_gnt), 64'h4);
        exp_rq.push_back(exp_of(2));
        tick(); mc_rs_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_rq.delete();
        #1;
        chk("t6_rst_mc_rq_vld", 64'(mc_rq_vld), 64'd0);
        chk("t6_rst_rtnctl", 64'(mc_rq_rtnctl), 64'd0);
        chk("t6_rst_gnt", 64'(req_gnt), 64'd0);
        chk("t6_rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("t6_rst_rsp_data", rsp_data, 64'd0);
        chk("t6_rst_idle", 64'(idle), 64'd1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_restart0", 64'(req_gnt), 64'h1);
        exp_rq.push_back(exp_of(0));
        tick();
        @(negedge clk);
        chk("t6_restart1", 64'(req_gnt), 64'h2);
        exp_rq.push_back(exp_of(1));
        tick(); req_vld = '0;
        tick(); tick();
        chk("end_drain_rq", 64'(exp_rq.size()), 64'd0);
        chk("end_drain_rs", 64'(exp_rs.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
